rsa_stim_ctrl: RTL



---
 rtl/rsa_stim_pkg.sv | 43 ++++
 rtl/rsa_vector_rom.sv | 40 ++++
 rtl/rsa_stim_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rsa_stim_pkg.sv
// Shared types and constants for the RSA stimulus controller and its vector ROM.
package rsa_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADED,
    ST_RUN,
    ST_SHOW
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CORE_RST,
    EV_ABORT,
    EV_LOAD,
    EV_GO,
    EV_PAGE
  } pb_ev_e;

  localparam int CNT_W    = 32;
  localparam int LED_RUN  = 4;
  localparam int LED_PASS = 5;
  localparam int LED_FAIL = 6;
  localparam int LED_TMO  = 7;

  // Number of 16-bit display pages for a given operand width.
  function automatic int pages_of(input int bits);
    return bits / 16;
  endfunction

  // Coincident button edges resolve by fixed priority; only the winner acts.
  function automatic pb_ev_e pb_decode(input logic [4:0] rise);
    pb_ev_e ev;
    ev = EV_NONE;
    if      (rise[0]) ev = EV_CORE_RST;
    else if (rise[3]) ev = EV_ABORT;
    else if (rise[1]) ev = EV_LOAD;
    else if (rise[2]) ev = EV_GO;
    else if (rise[4]) ev = EV_PAGE;
    return ev;
  endfunction

endpackage

// File: rtl/rsa_vector_rom.sv
// Combinational test-vector table: clamped index -> {M, E, N, expected M^E mod N}.
module rsa_vector_rom #(
  parameter int BITS = 64,
  parameter int NVEC = 16
) (
  input  logic [3:0]      idx,
  output logic [3:0]      sel,
  output logic [BITS-1:0] m,
  output logic [BITS-1:0] e,
  output logic [BITS-1:0] n,
  output logic [BITS-1:0] expected
);

  logic [15:0] m16, e16, n16, x16;

  // Eight encrypt/decrypt pairs; indices 8..15 alias onto 0..7.
  always_comb begin
    sel = (int'(idx) >= NVEC) ? 4'(NVEC - 1) : idx;
    m16 = '0;
    e16 = '0;
    n16 = '0;
    x16 = '0;
    case (sel[2:0])
      3'd0: begin m16 = 16'd190;  e16 = 16'd3;    n16 = 16'd1189; x16 = 16'd848;  end
      3'd1: begin m16 = 16'd848;  e16 = 16'd187;  n16 = 16'd1189; x16 = 16'd190;  end
      3'd2: begin m16 = 16'd65;   e16 = 16'd17;   n16 = 16'd3233; x16 = 16'd2790; end
      3'd3: begin m16 = 16'd2790; e16 = 16'd2753; n16 = 16'd3233; x16 = 16'd65;   end
      3'd4: begin m16 = 16'd2;    e16 = 16'd7;    n16 = 16'd143;  x16 = 16'd128;  end
      3'd5: begin m16 = 16'd128;  e16 = 16'd103;  n16 = 16'd143;  x16 = 16'd2;    end
      3'd6: begin m16 = 16'd5;    e16 = 16'd7;    n16 = 16'd143;  x16 = 16'd47;   end
      default: begin m16 = 16'd47; e16 = 16'd103; n16 = 16'd143;  x16 = 16'd5;    end
    endcase
  end

  assign m        = BITS'(m16);
  assign e        = BITS'(e16);
  assign n        = BITS'(n16);
  assign expected = BITS'(x16);

endmodule

// File: rtl/rsa_stim_ctrl.sv
// Board-side stimulus controller: loads a stored vector, runs the RSA core with a
// timeout, checks the result and pages it onto the 16-bit display.
module rsa_stim_ctrl
  import rsa_stim_pkg::*;
#(
  parameter int BITS    = 64,
  parameter int NVEC    = 16,
  parameter int TIMEOUT = 2**20
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [4:0]      PB,
  input  logic [7:0]      SW,
  output logic            CORE_RST,
  output logic            LOAD,
  output logic            GO,
  output logic [BITS-1:0] M,
  output logic [BITS-1:0] E,
  output logic [BITS-1:0] N,
  input  logic [BITS-1:0] RESULT,
  input  logic            DONE,
  output logic [15:0]     display,
  output logic [7:0]      led
);

  localparam int               PAGES    = pages_of(BITS);
  localparam int               PAGE_W   = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [4:0]        pb_q, pb_rise;
  pb_ev_e            ev;
  logic [3:0]        rom_sel, idx_q;
  logic [BITS-1:0]   rom_m, rom_e, rom_n, rom_x;
  logic [BITS-1:0]   expected_q, result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PAGE_W-1:0] page_q;
  logic              pass_q, fail_q, tmo_q;
  logic              do_rst, do_load, do_start, do_abort, do_page, do_done, do_tmo;
  logic [15:0]       display_d;
  logic              unused_sw;

  assign unused_sw = ^SW[6:4];
  assign pb_rise   = PB & ~pb_q;
  assign ev        = pb_decode(pb_rise);

  rsa_vector_rom #(
    .BITS (BITS),
    .NVEC (NVEC)
  ) u_rom (
    .idx      (SW[3:0]),
    .sel      (rom_sel),
    .m        (rom_m),
    .e        (rom_e),
    .n        (rom_n),
    .expected (rom_x)
  );

  // NOTE: every signal written here gets a default first; a path that leaves one
  // unassigned would make synthesis infer a latch.
  always_comb begin
    state_d  = state_q;
    do_rst   = 1'b0;
    do_load  = 1'b0;
    do_start = 1'b0;
    do_abort = 1'b0;
    do_page  = 1'b0;
    do_done  = 1'b0;
    do_tmo   = 1'b0;
    case (ev)
      EV_CORE_RST: begin
        do_rst  = 1'b1;
        state_d = ST_IDLE;
      end
      EV_ABORT: if (state_q == ST_RUN) begin
        do_abort = 1'b1;
        state_d  = ST_LOADED;
      end
      EV_LOAD: if (state_q != ST_RUN) begin
        do_load = 1'b1;
        state_d = ST_LOADED;
      end
      EV_GO: if (state_q == ST_LOADED) begin
        do_start = 1'b1;
        state_d  = ST_RUN;
      end
      EV_PAGE: do_page = 1'b1;
      default: ;
    endcase
    // Abort or core reset pre-empts completion; DONE beats the timeout.
    if (state_q == ST_RUN && !do_rst && !do_abort) begin
      if (DONE) begin
        do_done = 1'b1;
        state_d = ST_SHOW;
      end else if (cnt_q == LAST_CNT) begin
        do_tmo  = 1'b1;
        state_d = ST_SHOW;
      end
    end
  end

  always_comb begin
    display_d = '0;
    if (SW[7])                                   display_d = cnt_q[15:0];
    else if (state_q == ST_SHOW)                 display_d = result_q[{page_q, 4'b0000} +: 16];
    else if (state_q inside {ST_LOADED, ST_RUN}) display_d = M[{page_q, 4'b0000} +: 16];
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    pb_q <= PB;
    if (RESET) begin
      state_q    <= ST_IDLE;
      CORE_RST   <= 1'b0;
      LOAD       <= 1'b0;
      GO         <= 1'b0;
      M          <= '0;
      E          <= '0;
      N          <= '0;
      expected_q <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      page_q     <= '0;
      idx_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      display    <= '0;
    end else begin
      state_q  <= state_d;
      CORE_RST <= do_rst;
      LOAD     <= do_load;
      GO       <= (state_d == ST_RUN);
      display  <= display_d;

      if (do_start) begin
        cnt_q    <= '0;
        result_q <= '0;
      end else if (state_q == ST_RUN && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (do_load) begin
        idx_q      <= rom_sel;
        M          <= rom_m;
        E          <= rom_e;
        N          <= rom_n;
        expected_q <= rom_x;
        result_q   <= '0;
      end

      if (do_rst || do_load || do_start) begin
        pass_q <= 1'b0;
        fail_q <= 1'b0;
        tmo_q  <= 1'b0;
      end

      if (do_rst || do_load)
        page_q <= '0;
      else if (do_page)
        page_q <= (page_q == PAGE_W'(PAGES - 1)) ? '0 : page_q + PAGE_W'(1);

      if (do_done) begin
        result_q <= RESULT;
        pass_q   <= (RESULT == expected_q);
        fail_q   <= (RESULT != expected_q);
      end
      if (do_tmo) tmo_q <= 1'b1;
    end
  end

  always_comb begin
    led           = '0;
    led[3:0]      = idx_q;
    led[LED_RUN]  = GO;
    led[LED_PASS] = pass_q;
    led[LED_FAIL] = fail_q;
    led[LED_TMO]  = tmo_q;
  end

endmodule
